// File: rtl/free_list.sv
// ============================================================================
// free_list : circular free list of physical register indices for OoO rename
//             (optional checker: FREELIST_CHECK_EN)  -- rev 1.0
// ============================================================================
`default_nettype none

module free_list #(
  parameter int PHYS_REG_BITS = 6,
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              dequeue,
  output logic [PHYS_REG_BITS-1:0]                          deq_pd,
  output logic                                              empty,
  input  logic                                              commit_we,
  input  logic [PHYS_REG_BITS-1:0]                          commit_old_pd,
  input  logic                                              global_branch_signal,
  output logic [$clog2(NUM_PHYS_REGS-NUM_ARCH_REGS):0]      free_count,
  output logic                                              error
);

  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [PHYS_REG_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         rhead_q, rhead_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic                     error_q, error_d;
  logic                     deq_fire, overflow, commit_ok;
  logic                     double_free;

  // Pointers carry a wrap bit above the index so full and empty differ.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) return {~p[PTR_W-1], {IDX_W{1'b0}}};
    return p + PTR_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_diff(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    logic [PTR_W-1:0] ai;
    logic [PTR_W-1:0] bi;
    ai = {1'b0, a[IDX_W-1:0]};
    bi = {1'b0, b[IDX_W-1:0]};
    if (a[PTR_W-1] != b[PTR_W-1]) ai = ai + PTR_W'(DEPTH);
    return ai - bi;
  endfunction

  assign empty      = (head_q == tail_q);
  assign deq_pd     = mem_q[head_q[IDX_W-1:0]];
  assign free_count = ptr_diff(tail_q, head_q);
  assign error      = error_q;

  // A commit into a completely free list is only legal when the same cycle
  // also allocates, since the slot being overwritten is the one consumed.
  always_comb begin
    deq_fire  = dequeue && !empty && !global_branch_signal;
    overflow  = commit_we && (free_count == PTR_W'(DEPTH)) && !deq_fire;
    commit_ok = commit_we && !overflow && !double_free;
    error_d   = error_q | overflow | double_free;
    mem_d     = mem_q;
    head_d    = head_q;
    rhead_d   = rhead_q;
    tail_d    = tail_q;
    if (commit_ok) begin
      mem_d[tail_q[IDX_W-1:0]] = commit_old_pd;
      tail_d                   = ptr_inc(tail_q);
      rhead_d                  = ptr_inc(rhead_q);
    end
    if (global_branch_signal) begin
      head_d = rhead_d;
    end else if (deq_fire) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PHYS_REG_BITS'(NUM_ARCH_REGS + i);
      end
      head_q  <= '0;
      rhead_q <= '0;
      tail_q  <= {1'b1, {IDX_W{1'b0}}};
      error_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      rhead_q <= rhead_d;
      tail_q  <= tail_d;
      error_q <= error_d;
    end
  end

`ifdef FREELIST_CHECK_EN
  localparam logic [NUM_PHYS_REGS-1:0] BITMAP_RST =
      {{DEPTH{1'b1}}, {NUM_ARCH_REGS{1'b0}}};

  logic [NUM_PHYS_REGS-1:0] bitmap_q, bitmap_d;
  int                       rh_idx, live_cnt, off;

  assign double_free = commit_we &&
                       ((commit_old_pd == '0) || bitmap_q[commit_old_pd]);

  // On flush the free set is exactly the slots in [retire_head, tail).
  always_comb begin
    bitmap_d = bitmap_q;
    rh_idx   = int'(rhead_d[IDX_W-1:0]);
    live_cnt = int'(ptr_diff(tail_d, rhead_d));
    off      = 0;
    if (global_branch_signal) begin
      bitmap_d = '0;
      for (int j = 0; j < DEPTH; j++) begin
        off = (j >= rh_idx) ? (j - rh_idx) : (j + DEPTH - rh_idx);
        if (off < live_cnt) bitmap_d[mem_d[j]] = 1'b1;
      end
    end else begin
      if (deq_fire)  bitmap_d[deq_pd]        = 1'b0;
      if (commit_ok) bitmap_d[commit_old_pd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) bitmap_q <= BITMAP_RST;
    else     bitmap_q <= bitmap_d;
  end
`else
  assign double_free = 1'b0;
`endif

endmodule

`default_nettype wire
